// File: rtl/multi_clock_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional phase-alignment input is enabled with the CLKDIV_SYNC_EN macro.
package clock_div_pkg;

    localparam int unsigned DEFAULT_CLOCK_HZ = 50_000_000;
    localparam int          DEFAULT_WIDTH    = 32;

    // A channel whose active divisor is zero is stopped; otherwise it runs.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_STOP = 1'b1;

    function automatic int chan_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_clock_div_if.sv
// Per-channel divisor write bus (plus the sync pulse when CLKDIV_SYNC_EN is defined).
interface multi_clock_div_if
    import clock_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             wr;
    logic [WIDTH-1:0] data;
`ifdef CLKDIV_SYNC_EN
    logic             sync;

    modport master (output wr, output data, output sync);
    modport slave  (input  wr, input  data, input  sync);
`else
    modport master (output wr, output data);
    modport slave  (input  wr, input  data);
`endif

endinterface

// File: rtl/multi_clock_div_chan.sv
// One divider channel: counter, active/shadow divisors, tick strobe and square wave.
// Phase alignment via the sync pulse exists only when CLKDIV_SYNC_EN is defined.
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_DIV = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    multi_clock_div_if.slave wr_if,
    output logic             o_tick,
    output logic             o_out,
    output logic [WIDTH-1:0] o_div
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_act;
    logic [WIDTH-1:0] r_div_shd;
    logic             r_tick;
    logic             r_out;

    logic [0:0]       w_state;
    logic             w_term;
    logic [WIDTH-1:0] w_next_div;

    assign w_state    = (r_div_act == '0) ? ST_STOP : ST_RUN;
    assign w_term     = (r_cnt >= (r_div_act - WIDTH'(1)));
    // A write landing on the terminal-count edge wins over the old shadow value.
    assign w_next_div = wr_if.wr ? wr_if.data : r_div_shd;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_div_act <= RST_DIV;
            r_div_shd <= RST_DIV;
            r_tick    <= 1'b0;
            r_out     <= 1'b0;
        end
`ifdef CLKDIV_SYNC_EN
        else if (wr_if.sync) begin
            r_cnt     <= '0;
            r_div_act <= w_next_div;
            r_div_shd <= w_next_div;
            r_tick    <= 1'b0;
            r_out     <= 1'b0;
        end
`endif
        else begin
            r_div_shd <= w_next_div;
            case (w_state)
                ST_RUN: begin
                    if (w_term) begin
                        r_cnt     <= '0;
                        r_out     <= ~r_out;
                        r_tick    <= 1'b1;
                        r_div_act <= w_next_div;
                    end else begin
                        r_cnt  <= r_cnt + WIDTH'(1);
                        r_tick <= 1'b0;
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    if (wr_if.wr) begin
                        r_div_act <= wr_if.data;
                    end
                end
            endcase
        end
    end

    assign o_tick = r_tick;
    assign o_out  = r_out;
    assign o_div  = r_div_act;

endmodule

// File: rtl/multi_clock_div.sv
// Multi-channel programmable clock divider / tick generator top level.
// Define CLKDIV_SYNC_EN to add the i_sync phase-alignment input.
module multi_clock_div
    import clock_div_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned CLOCK_HZ  = DEFAULT_CLOCK_HZ,
    parameter int unsigned RESET_DIV = CLOCK_HZ / 2,
    localparam int         CHW       = chan_idx_w(NCH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr,
    input  logic [CHW-1:0]       i_wr_ch,
    input  logic [WIDTH-1:0]     i_wr_data,
`ifdef CLKDIV_SYNC_EN
    input  logic                 i_sync,
`endif
    output logic [NCH-1:0]       o_tick,
    output logic [NCH-1:0]       o_out,
    output logic [NCH*WIDTH-1:0] o_div
);

    localparam logic [WIDTH-1:0] L_RST_DIV = WIDTH'(RESET_DIV);

    // Indices with no matching channel decode to no write at all.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        multi_clock_div_if #(.WIDTH(WIDTH)) w_wr_if ();

        assign w_wr_if.wr   = i_wr && (i_wr_ch == CHW'(gi));
        assign w_wr_if.data = i_wr_data;
`ifdef CLKDIV_SYNC_EN
        assign w_wr_if.sync = i_sync;
`endif

        clock_div_chan #(
            .WIDTH   (WIDTH),
            .RST_DIV (L_RST_DIV)
        ) u_chan (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .wr_if   (w_wr_if),
            .o_tick  (o_tick[gi]),
            .o_out   (o_out[gi]),
            .o_div   (o_div[gi*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_clock_div.sv
// Scoreboarded random/directed bench for multi_clock_div against an event-time model.
module tb_multi_clock_div;
    import clock_div_pkg::*;

    localparam int NCH       = 4;
    localparam int WIDTH     = 8;
    localparam int RESET_DIV = 3;
    localparam int CHW       = chan_idx_w(NCH);

    logic clk = 1'b0;
    logic rst;
    logic [CHW-1:0]       wr_ch;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       out;
    logic [NCH*WIDTH-1:0] div;

    always #5 clk = ~clk;

    multi_clock_div_if #(.WIDTH(WIDTH)) bus ();

    multi_clock_div #(
        .NCH       (NCH),
        .WIDTH     (WIDTH),
        .CLOCK_HZ  (6),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_wr      (bus.wr),
        .i_wr_ch   (wr_ch),
        .i_wr_data (bus.data),
`ifdef CLKDIV_SYNC_EN
        .i_sync    (bus.sync),
`endif
        .o_tick    (tick),
        .o_out     (out),
        .o_div     (div)
    );

    typedef struct {
        int                   edge_no;
        logic [NCH-1:0]       tick;
        logic [NCH-1:0]       out;
        logic [NCH*WIDTH-1:0] div;
    } exp_t;

    exp_t q[$];

    // Model: each channel knows the absolute edge of its next tick.
    int m_act  [NCH];
    int m_shd  [NCH];
    int m_next [NCH];
    bit m_out  [NCH];
    bit m_tick [NCH];
    int t      = 0;
    int edges  = 0;
    int n_vec  = 0;
    int n_miss = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic apply(input bit r, input bit s, input bit w, input int ch, input int data);
        exp_t e;
        rst      = r;
        bus.wr   = w;
        wr_ch    = CHW'(ch);
        bus.data = WIDTH'(data);
`ifdef CLKDIV_SYNC_EN
        bus.sync = s;
`endif
        t++;
        for (int c = 0; c < NCH; c++) begin
            bit hit;
            hit = w && (ch == c);
            if (r) begin
                m_act[c] = RESET_DIV; m_shd[c] = RESET_DIV;
                m_out[c] = 0; m_tick[c] = 0; m_next[c] = t + RESET_DIV;
            end else if (s) begin
                if (hit) m_shd[c] = data;
                m_act[c] = m_shd[c]; m_out[c] = 0; m_tick[c] = 0;
                m_next[c] = t + m_act[c];
            end else if (m_act[c] == 0) begin
                m_tick[c] = 0;
                if (hit) begin
                    m_act[c] = data; m_shd[c] = data; m_next[c] = t + data;
                end
            end else if (t == m_next[c]) begin
                m_tick[c] = 1; m_out[c] = !m_out[c];
                if (hit) m_shd[c] = data;
                m_act[c] = m_shd[c]; m_next[c] = t + m_act[c];
            end else begin
                m_tick[c] = 0;
                if (hit) m_shd[c] = data;
            end
            e.tick[c] = m_tick[c];
            e.out[c]  = m_out[c];
            e.div[c*WIDTH +: WIDTH] = WIDTH'(m_act[c]);
        end
        e.edge_no = t;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every edge that has already happened.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].edge_no <= edges) begin
                e = q.pop_front();
                n_vec++;
                if (tick !== e.tick || out !== e.out || div !== e.div) begin
                    n_miss++;
                    $display("FAIL edge %0d: tick=%b exp %b out=%b exp %b div=%h exp %h",
                             e.edge_no, tick, e.tick, out, e.out, div, e.div);
                end else begin
                    $display("vec %0d edge %0d tick=%b out=%b div=%h ok",
                             n_vec, e.edge_no, tick, out, div);
                end
            end
        end
    end

    initial begin
        int k;
        bit r, s, w;
        apply(1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        idle(12);
        // Mid-period rate changes: fast, stop, slower.
        apply(0, 0, 1, 1, 1);
        apply(0, 0, 1, 2, 0);
        apply(0, 0, 1, 3, 5);
        idle(16);
        apply(0, 0, 1, 2, 4);
        idle(14);
        // Write landing exactly on ch0's terminal-count edge.
        k = 0;
        while (!(m_act[0] != 0 && m_next[0] == t + 1) && k < 20) begin
            idle(1); k++;
        end
        apply(0, 0, 1, 0, 7);
        idle(16);
        apply(0, 0, 1, 0, 255);
        idle(520);
        // Reset while ch0's square wave is high and mid-period.
        k = 0;
        while (!(m_out[0] && m_act[0] > 1 && m_next[0] != t + 1) && k < 600) begin
            idle(1); k++;
        end
        apply(1, 0, 0, 0, 0);
        idle(8);
`ifdef CLKDIV_SYNC_EN
        apply(0, 0, 1, 0, 2);
        apply(0, 0, 1, 1, 3);
        apply(0, 0, 1, 2, 5);
        apply(0, 0, 1, 3, 7);
        idle(23);
        apply(0, 1, 0, 0, 0);
        idle(20);
`endif
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 299) == 0);
`ifdef CLKDIV_SYNC_EN
            s = ($urandom_range(0, 99) == 0);
`else
            s = 0;
`endif
            w = ($urandom_range(0, 3) == 0);
            k = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 9));
            apply(r, s, w, int'($urandom_range(0, NCH - 1)), k);
        end
        apply(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
